// File: rtl/sync_fifo_pkg.sv
// Shared definitions for the threshold sync FIFO: level sizing, depth derivation
// and elaboration-time range checks for the almost-full/almost-empty thresholds.
package sync_fifo_pkg;

    typedef enum logic [1:0] {
        LVL_HOLD,
        LVL_INC,
        LVL_DEC
    } lvl_op_e;

    function automatic int unsigned level_width(input int unsigned ptr_w);
        return ptr_w + 1;
    endfunction

    function automatic int unsigned fifo_depth(input int unsigned ptr_w);
        return 1 << ptr_w;
    endfunction

    function automatic bit thresh_ok(input int unsigned ptr_w,
                                     input int unsigned afull_thr,
                                     input int unsigned aempty_thr);
        return (ptr_w >= 1) &&
               (afull_thr >= 1) && (afull_thr <= fifo_depth(ptr_w)) &&
               (aempty_thr <= fifo_depth(ptr_w) - 1);
    endfunction

endpackage

// File: rtl/sync_fifo_ram.sv
// Dual-port storage for sync_fifo_thresh: synchronous write, asynchronous read.
module sync_fifo_ram
    import sync_fifo_pkg::*;
#(
    parameter int unsigned pDataWidth = 8,
    parameter int unsigned pPtrWidth  = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_We,
    input  logic [pPtrWidth-1:0]  iv_WrAddr,
    input  logic [pDataWidth-1:0] iv_WrData,
    input  logic [pPtrWidth-1:0]  iv_RdAddr,
    output logic [pDataWidth-1:0] ov_RdData
);

    logic [pDataWidth-1:0] mem [fifo_depth(pPtrWidth)];

    always_ff @(posedge i_Clk) begin
        if (i_We) begin
            mem[iv_WrAddr] <= iv_WrData;
        end
    end

    assign ov_RdData = mem[iv_RdAddr];

endmodule

// File: rtl/sync_fifo_thresh.sv
// Single-clock show-ahead FIFO with fill level, almost-full/empty thresholds, flush
// and write-through-when-full. Sticky o_Ovf/o_Udf only when SYNC_FIFO_ERR_FLAGS_EN is defined.
module sync_fifo_thresh
    import sync_fifo_pkg::*;
#(
    parameter int unsigned pDataWidth = 8,
    parameter int unsigned pPtrWidth  = 4,
    parameter int unsigned pAFullThr  = 2**pPtrWidth - 2,
    parameter int unsigned pAEmptyThr = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_ARst_L,
    input  logic [pDataWidth-1:0] iv_Din,
    input  logic                  i_Wr,
    input  logic                  i_Rd,
    input  logic                  i_Flush,
    input  logic                  i_ClrErr,
    output logic [pDataWidth-1:0] ov_Q,
    output logic                  o_Full,
    output logic                  o_Empty,
    output logic                  o_AFull,
    output logic                  o_AEmpty,
    output logic [pPtrWidth:0]    ov_Level,
    output logic                  o_Ovf,
    output logic                  o_Udf
);

    localparam int unsigned LW = level_width(pPtrWidth);
    localparam logic [LW-1:0] DEPTH_L  = LW'(fifo_depth(pPtrWidth));
    localparam logic [LW-1:0] AFULL_L  = LW'(pAFullThr);
    localparam logic [LW-1:0] AEMPTY_L = LW'(pAEmptyThr);

    generate
        if (!thresh_ok(pPtrWidth, pAFullThr, pAEmptyThr)) begin : g_bad_cfg
            $error("sync_fifo_thresh: threshold or pointer width out of range");
        end
    endgenerate

    logic [pPtrWidth-1:0] wr_ptr;
    logic [pPtrWidth-1:0] rd_ptr;
    logic [LW-1:0]        level;
    logic                 rdv;
    logic                 wrv;
    logic                 ram_we;
    lvl_op_e              lvl_op;

    // Flags decode only the registered level, so no request reaches them combinationally.
    assign o_Full   = (level == DEPTH_L);
    assign o_Empty  = (level == '0);
    assign o_AFull  = (level >= AFULL_L);
    assign o_AEmpty = (level <= AEMPTY_L);
    assign ov_Level = level;

    assign rdv    = i_Rd & ~o_Empty;
    assign wrv    = i_Wr & (~o_Full | rdv);
    assign ram_we = wrv & ~i_Flush;

    always_comb begin
        lvl_op = LVL_HOLD;
        if (wrv && !rdv) begin
            lvl_op = LVL_INC;
        end else if (rdv && !wrv) begin
            lvl_op = LVL_DEC;
        end
    end

    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (i_Flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wrv) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rdv) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case (lvl_op)
                LVL_INC: level <= level + 1'b1;
                LVL_DEC: level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    sync_fifo_ram #(
        .pDataWidth(pDataWidth),
        .pPtrWidth (pPtrWidth)
    ) u_ram (
        .i_Clk    (i_Clk),
        .i_We     (ram_we),
        .iv_WrAddr(wr_ptr),
        .iv_WrData(iv_Din),
        .iv_RdAddr(rd_ptr),
        .ov_RdData(ov_Q)
    );

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic udf_q;

    // Set takes priority over a simultaneous clear; flush freezes both flags.
    always_ff @(posedge i_Clk or negedge i_ARst_L) begin
        if (!i_ARst_L) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else if (!i_Flush) begin
            if (i_Wr && !wrv) begin
                ovf_q <= 1'b1;
            end else if (i_ClrErr) begin
                ovf_q <= 1'b0;
            end
            if (i_Rd && o_Empty) begin
                udf_q <= 1'b1;
            end else if (i_ClrErr) begin
                udf_q <= 1'b0;
            end
        end
    end

    assign o_Ovf = ovf_q;
    assign o_Udf = udf_q;
`else
    logic unused_clr_err;
    assign unused_clr_err = i_ClrErr;
    assign o_Ovf = 1'b0;
    assign o_Udf = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_thresh.sv
// Directed self-checking bench for sync_fifo_thresh at default parameters (depth 16).
module tb_sync_fifo_thresh;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif

    logic       i_Clk = 1'b0;
    logic       i_ARst_L = 1'b0;
    logic [7:0] iv_Din = '0;
    logic       i_Wr = 1'b0;
    logic       i_Rd = 1'b0;
    logic       i_Flush = 1'b0;
    logic       i_ClrErr = 1'b0;
    logic [7:0] ov_Q;
    logic       o_Full, o_Empty, o_AFull, o_AEmpty;
    logic [4:0] ov_Level;
    logic       o_Ovf, o_Udf;

    int checks = 0;
    int errors = 0;

    sync_fifo_thresh #(
        .pDataWidth(8),
        .pPtrWidth (4),
        .pAFullThr (14),
        .pAEmptyThr(2)
    ) dut (
        .i_Clk   (i_Clk),
        .i_ARst_L(i_ARst_L),
        .iv_Din  (iv_Din),
        .i_Wr    (i_Wr),
        .i_Rd    (i_Rd),
        .i_Flush (i_Flush),
        .i_ClrErr(i_ClrErr),
        .ov_Q    (ov_Q),
        .o_Full  (o_Full),
        .o_Empty (o_Empty),
        .o_AFull (o_AFull),
        .o_AEmpty(o_AEmpty),
        .ov_Level(ov_Level),
        .o_Ovf   (o_Ovf),
        .o_Udf   (o_Udf)
    );

    always #5 i_Clk = ~i_Clk;

    // Drive one cycle of requests, return 1 time unit after the edge with inputs idle.
    task automatic cycle(input logic wr, input logic rd, input logic [7:0] din,
                         input logic fl, input logic clr);
        i_Wr = wr; i_Rd = rd; iv_Din = din; i_Flush = fl; i_ClrErr = clr;
        @(posedge i_Clk);
        #1;
        i_Wr = 1'b0; i_Rd = 1'b0; i_Flush = 1'b0; i_ClrErr = 1'b0;
    endtask

    task automatic test_reset;
        #2;
        checks++; if (ov_Level !== 5'd0) begin errors++; $display("FAIL rst_level: got %0d expected 0", ov_Level); end
        checks++; if ({o_Empty, o_AEmpty, o_Full, o_AFull} !== 4'b1100) begin errors++; $display("FAIL rst_flags: got %b expected 1100", {o_Empty, o_AEmpty, o_Full, o_AFull}); end
        checks++; if ({o_Ovf, o_Udf} !== 2'b00) begin errors++; $display("FAIL rst_err: got %b expected 00", {o_Ovf, o_Udf}); end
        @(negedge i_Clk);
        i_ARst_L = 1'b1;
    endtask

    task automatic test_fill_drain;
        logic [7:0] d;
        for (int i = 1; i <= 15; i++) begin
            d = 8'(8'h10 + i);
            cycle(1'b1, 1'b0, d, 1'b0, 1'b0);
            checks++; if (ov_Level !== 5'(i)) begin errors++; $display("FAIL fill_level: got %0d expected %0d", ov_Level, i); end
            checks++; if (o_AFull !== (i >= 14)) begin errors++; $display("FAIL fill_afull: got %b expected %b at level %0d", o_AFull, (i >= 14), i); end
            checks++; if (o_AEmpty !== (i <= 2)) begin errors++; $display("FAIL fill_aempty: got %b expected %b at level %0d", o_AEmpty, (i <= 2), i); end
            checks++; if ({o_Full, o_Empty} !== 2'b00) begin errors++; $display("FAIL fill_full_empty: got %b expected 00", {o_Full, o_Empty}); end
        end
        for (int i = 0; i < 15; i++) begin
            d = 8'(8'h11 + i);
            checks++; if (ov_Q !== d) begin errors++; $display("FAIL drain_q: got %h expected %h", ov_Q, d); end
            cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        end
        checks++; if ({o_Empty, ov_Level} !== {1'b1, 5'd0}) begin errors++; $display("FAIL drain_empty: got %b/%0d expected 1/0", o_Empty, ov_Level); end
    endtask

    task automatic test_full_rw;
        logic [7:0] d;
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
        checks++; if ({o_Full, o_AFull, ov_Level} !== {2'b11, 5'd16}) begin errors++; $display("FAIL full_state: got %b%b/%0d expected 11/16", o_Full, o_AFull, ov_Level); end
        cycle(1'b1, 1'b1, 8'hA5, 1'b0, 1'b0);
        checks++; if ({o_Full, ov_Level} !== {1'b1, 5'd16}) begin errors++; $display("FAIL full_rw_level: got %b/%0d expected 1/16", o_Full, ov_Level); end
        checks++; if (o_Ovf !== 1'b0) begin errors++; $display("FAIL full_rw_ovf: got %b expected 0", o_Ovf); end
        for (int i = 0; i < 16; i++) begin
            d = (i == 15) ? 8'hA5 : 8'(8'h41 + i);
            checks++; if (ov_Q !== d) begin errors++; $display("FAIL full_rw_q: got %h expected %h at read %0d", ov_Q, d, i); end
            cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        end
        checks++; if (o_Empty !== 1'b1) begin errors++; $display("FAIL full_rw_empty: got %b expected 1", o_Empty); end
    endtask

    task automatic test_empty_rw;
        cycle(1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
        checks++; if (ov_Level !== 5'd1) begin errors++; $display("FAIL empty_rw_level: got %0d expected 1", ov_Level); end
        checks++; if (ov_Q !== 8'h3C) begin errors++; $display("FAIL empty_rw_q: got %h expected 3c", ov_Q); end
        checks++; if (o_Udf !== 1'b0) begin errors++; $display("FAIL empty_rw_udf: got %b expected 0", o_Udf); end
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checks++; if (o_Empty !== 1'b1) begin errors++; $display("FAIL empty_rw_drain: got %b expected 1", o_Empty); end
    endtask

    task automatic test_errors;
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 8'(8'h50 + i), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'hFF, 1'b0, 1'b0);
        checks++; if (o_Ovf !== ERR_EN) begin errors++; $display("FAIL ovf_set: got %b expected %b", o_Ovf, ERR_EN); end
        checks++; if ({ov_Level, ov_Q} !== {5'd16, 8'h50}) begin errors++; $display("FAIL ovf_nowrite: got %0d/%h expected 16/50", ov_Level, ov_Q); end
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checks++; if (o_Ovf !== ERR_EN) begin errors++; $display("FAIL ovf_sticky: got %b expected %b", o_Ovf, ERR_EN); end
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        checks++; if ({o_Udf, ov_Level} !== {ERR_EN, 5'd0}) begin errors++; $display("FAIL udf_set: got %b/%0d expected %b/0", o_Udf, ov_Level, ERR_EN); end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if ({o_Ovf, o_Udf} !== 2'b00) begin errors++; $display("FAIL err_clear: got %b expected 00", {o_Ovf, o_Udf}); end
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        checks++; if (o_Udf !== ERR_EN) begin errors++; $display("FAIL udf_set_wins: got %b expected %b", o_Udf, ERR_EN); end
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    endtask

    task automatic test_flush;
        for (int i = 0; i < 9; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
        checks++; if (ov_Level !== 5'd9) begin errors++; $display("FAIL flush_pre_level: got %0d expected 9", ov_Level); end
        cycle(1'b1, 1'b0, 8'hEE, 1'b1, 1'b0);
        checks++; if ({ov_Level, o_Empty, o_AEmpty} !== {5'd0, 2'b11}) begin errors++; $display("FAIL flush_state: got %0d/%b%b expected 0/11", ov_Level, o_Empty, o_AEmpty); end
        cycle(1'b1, 1'b0, 8'h77, 1'b0, 1'b0);
        checks++; if ({ov_Q, ov_Level} !== {8'h77, 5'd1}) begin errors++; $display("FAIL flush_post_write: got %h/%0d expected 77/1", ov_Q, ov_Level); end
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
        checks++; if (o_Udf !== 1'b0) begin errors++; $display("FAIL flush_udf_ignored: got %b expected 0", o_Udf); end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0);
        checks++; if (ov_Level !== 5'd7) begin errors++; $display("FAIL arst_pre_level: got %0d expected 7", ov_Level); end
        #2;
        i_ARst_L = 1'b0;
        #1;
        checks++; if ({ov_Level, o_Empty, o_AEmpty, o_Full, o_AFull} !== {5'd0, 4'b1100}) begin errors++; $display("FAIL arst_immediate: got %0d/%b expected 0/1100", ov_Level, {o_Empty, o_AEmpty, o_Full, o_AFull}); end
        @(negedge i_Clk);
        i_ARst_L = 1'b1;
        cycle(1'b1, 1'b0, 8'h99, 1'b0, 1'b0);
        checks++; if ({ov_Q, ov_Level} !== {8'h99, 5'd1}) begin errors++; $display("FAIL arst_post_write: got %h/%0d expected 99/1", ov_Q, ov_Level); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_full_rw();
        test_empty_rw();
        test_errors();
        test_flush();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sync_fifo_thresh.md
# sync_fifo_thresh

Parametrised single-clock show-ahead FIFO, next generation of the team's small sync FIFO, used as the elastic buffer between SGMII PCS code-group/data stages. Adds a fill-level output, programmable almost-full/almost-empty thresholds, synchronous flush, and write-through-when-full. Optional sticky overflow/underflow error flags are compiled in by macro.

## Interface
- pDataWidth, 8, data word width
- pPtrWidth, 4, address width; depth pDepth = 2**pPtrWidth (pPtrWidth >= 1)
- pAFullThr, 2**pPtrWidth-2, o_AFull asserts when level >= this (1..pDepth)
- pAEmptyThr, 2, o_AEmpty asserts when level <= this (0..pDepth-1)

- i_Clk  in  1  clock, rising edge; the single clock of the block
- i_ARst_L  in  1  asynchronous, active-low reset
- iv_Din  in  pDataWidth  write data
- i_Wr  in  1  write request
- i_Rd  in  1  read request / acknowledge of current ov_Q
- i_Flush  in  1  synchronous clear of pointers and level
- i_ClrErr  in  1  clears o_Ovf/o_Udf
- ov_Q  out  pDataWidth  head-of-FIFO word (valid when o_Empty=0)
- o_Full, o_Empty  out  1 each  level==pDepth / level==0
- o_AFull, o_AEmpty  out  1 each  threshold flags
- ov_Level  out  pPtrWidth+1  current occupancy 0..pDepth
- o_Ovf, o_Udf  out  1 each  sticky error flags

## Operation
- Reset (i_ARst_L=0, async): rd/wr pointers=0, level=0, o_Ovf=o_Udf=0 ⇒ o_Empty=1, o_AEmpty=1, o_Full=0, o_AFull=0, ov_Level=0. RAM not reset; ov_Q undefined while empty.
- Read valid: rdv = i_Rd & ~o_Empty. Write valid: wrv = i_Wr & (~o_Full | rdv) — write accepted when full if a valid read occurs the same cycle.
- wrv: RAM[wrptr] <= iv_Din, wrptr+1 (wraps mod pDepth). rdv: rdptr+1 (wraps).
- Level: +1 on wrv&~rdv, −1 on rdv&~wrv, unchanged otherwise; never leaves 0..pDepth.
- Flush: highest priority; next edge pointers and level = 0, regardless of i_Wr/i_Rd that cycle; RAM and error flags untouched.
- Flags decoded from registered level only (no combinational path from i_Wr/i_Rd).
- Error flags: o_Ovf sets on i_Wr & ~wrv; o_Udf sets on i_Rd & o_Empty; both clear on i_ClrErr; set wins over simultaneous clear. Ignored while i_Flush=1.

## Timing
- Write-to-read latency 1: word written at edge k appears on ov_Q and o_Empty falls after edge k.
- ov_Q = RAM[rdptr], combinational from RAM/pointer; i_Rd high at edge consumes ov_Q, next word visible after that edge.
- Simultaneous read+write when empty: write accepted, read ignored (rdv=0), level becomes 1.
- Simultaneous read+write when full: both accepted, level stays pDepth, no overflow.
- All flags/level update exactly one edge after the causing request.

## Configuration
- SYNC_FIFO_ERR_FLAGS_EN defined: o_Ovf/o_Udf sticky logic and i_ClrErr implemented as above.
- Not defined: no error registers; o_Ovf=o_Udf=0 constantly, i_ClrErr ignored; ports remain for interface stability. FIFO data behaviour identical.

## Structure
- Shared package sync_fifo_pkg: level-width function/constant (pPtrWidth+1), pDepth derivation, threshold range checks.
- Sub-module sync_fifo_ram: dual-port RAM, synchronous write, asynchronous read, parametrised by pDataWidth/pPtrWidth; control (pointers, level, flags) stays in sync_fifo_thresh.

## Test plan
- Reset, then write 0x11..0x1F (15 words, pPtrWidth=4) -> ov_Level=15, o_AFull=1 at level 14, o_Full=0; read all -> ov_Q sequence 0x11..0x1F, o_Empty=1.
- Fill to 16, assert i_Wr+i_Rd with iv_Din=0xA5 -> level stays 16, o_Ovf=0, 0xA5 emerges as 16th read after wrap.
- Empty, i_Wr+i_Rd with 0x3C -> level=1, ov_Q=0x3C next cycle, o_Udf=0 (macro on).
- Full, i_Wr alone -> o_Ovf=1 sticky, level=16; empty, i_Rd -> o_Udf=1; i_ClrErr -> both 0; macro off -> both always 0.
- Level 9, i_Flush with i_Wr=1 -> next cycle level=0, o_Empty=1, o_AEmpty=1; write 0x77 -> ov_Q=0x77.
- Async reset mid-stream at level 7 -> outputs immediately at reset values, first post-reset write read back correctly.
